// File: rtl/matrix_scan_decoder.sv
// matrix_scan_decoder
// Snoops a row-multiplexed 8x8 bicolour LED matrix drive. Each registered row
// sample is written into a shadow frame. Once all eight rows have been seen,
// the shadow frame is committed to a frame buffer that can be read back by row.
// Row-decode and row-order errors are reported as sticky flags.

module matrix_scan_decoder #(
   parameter int STRICT_ORDER = 1
) (
   input  logic       clk_1kHz,
   input  logic       rst,
   input  logic [7:0] row,
   input  logic [7:0] col_r,
   input  logic [7:0] col_g,
   input  logic       err_clr,
   input  logic [2:0] rd_row_sel,
   output logic [7:0] rd_r,
   output logic [7:0] rd_g,
   output logic       frame_pulse,
   output logic       frame_valid,
   output logic [7:0] frame_cnt,
   output logic       row_err,
   output logic       seq_err
);

   localparam bit STRICT_EN = (STRICT_ORDER != 32'sd0);

   // Number of active (low) row lines in a sample.
   function automatic logic [3:0] low_count(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i] == 1'b0) begin
            n = n + 4'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Index of the highest active (low) row line. Only meaningful when exactly
   // one line is low.
   function automatic logic [2:0] low_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i] == 1'b0) begin
            idx = i[2:0];
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [7:0] row_q_r;
   logic [7:0] col_r_q_r;
   logic [7:0] col_g_q_r;

   logic [7:0] shadow_r_r [8];
   logic [7:0] shadow_g_r [8];
   logic [7:0] frame_r_r  [8];
   logic [7:0] frame_g_r  [8];
   logic [7:0] seen_r;
   logic [2:0] last_row_r;
   logic       first_done_r;

   logic [3:0] low_cnt_s;
   logic [2:0] row_idx_s;
   logic [2:0] next_row_s;
   logic       is_row_s;
   logic       is_multi_s;
   logic [7:0] seen_next_s;
   logic       commit_s;
   logic       seq_bad_s;
   logic [7:0] shadow_r_next_s [8];
   logic [7:0] shadow_g_next_s [8];

   // Input stage: all decoding works on this registered copy.
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         row_q_r   <= 8'hFF;
         col_r_q_r <= 8'h00;
         col_g_q_r <= 8'h00;
      end else begin
         row_q_r   <= row;
         col_r_q_r <= col_r;
         col_g_q_r <= col_g;
      end
   end

   // Classify the sample and work out the next shadow contents, seen mask,
   // commit condition and order check.
   always_comb begin
      low_cnt_s   = low_count(row_q_r);
      row_idx_s   = low_index(row_q_r);
      next_row_s  = last_row_r + 3'd1;
      is_row_s    = (low_cnt_s == 4'd1);
      is_multi_s  = (low_cnt_s > 4'd1);
      seen_next_s = seen_r;
      commit_s    = 1'b0;
      seq_bad_s   = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (is_row_s && (row_idx_s == i[2:0])) begin
            shadow_r_next_s[i] = col_r_q_r;
            shadow_g_next_s[i] = col_g_q_r;
         end else begin
            shadow_r_next_s[i] = shadow_r_r[i];
            shadow_g_next_s[i] = shadow_g_r[i];
         end
      end

      if (is_row_s) begin
         seen_next_s = seen_r | (8'd1 << row_idx_s);
         commit_s    = (seen_next_s == 8'hFF);
      end else begin
         seen_next_s = seen_r;
         commit_s    = 1'b0;
      end

      if (STRICT_EN && is_row_s && first_done_r &&
          (row_idx_s != last_row_r) && (row_idx_s != next_row_s)) begin
         seq_bad_s = 1'b1;
      end else begin
         seq_bad_s = 1'b0;
      end
   end

   // Shadow capture: row writes, seen tracking (cleared on commit), last row.
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            shadow_r_r[i] <= 8'h00;
            shadow_g_r[i] <= 8'h00;
         end
         seen_r       <= 8'h00;
         last_row_r   <= 3'd0;
         first_done_r <= 1'b0;
      end else if (is_row_s) begin
         for (int i = 0; i < 8; i++) begin
            shadow_r_r[i] <= shadow_r_next_s[i];
            shadow_g_r[i] <= shadow_g_next_s[i];
         end
         seen_r       <= commit_s ? 8'h00 : seen_next_s;
         last_row_r   <= row_idx_s;
         first_done_r <= 1'b1;
      end else begin
         seen_r       <= seen_r;
         last_row_r   <= last_row_r;
         first_done_r <= first_done_r;
      end
   end

   // Frame buffer and frame status: updated only when a frame completes.
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            frame_r_r[i] <= 8'h00;
            frame_g_r[i] <= 8'h00;
         end
         frame_pulse <= 1'b0;
         frame_valid <= 1'b0;
         frame_cnt   <= 8'd0;
      end else if (commit_s) begin
         for (int i = 0; i < 8; i++) begin
            frame_r_r[i] <= shadow_r_next_s[i];
            frame_g_r[i] <= shadow_g_next_s[i];
         end
         frame_pulse <= 1'b1;
         frame_valid <= 1'b1;
         frame_cnt   <= frame_cnt + 8'd1;
      end else begin
         frame_pulse <= 1'b0;
         frame_valid <= frame_valid;
         frame_cnt   <= frame_cnt;
      end
   end

   // Sticky error flags; a new error on the clearing edge keeps the flag set.
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         row_err <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         row_err <= is_multi_s | (row_err & ~err_clr);
         seq_err <= seq_bad_s  | (seq_err & ~err_clr);
      end
   end

   // Registered read-back; sees the frame buffer as it was before this edge.
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         rd_r <= 8'h00;
         rd_g <= 8'h00;
      end else begin
         rd_r <= frame_r_r[rd_row_sel];
         rd_g <= frame_g_r[rd_row_sel];
      end
   end

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Self-checking bench for matrix_scan_decoder: a strict-order and a
// relaxed-order instance share the same stimulus.

module tb_matrix_scan_decoder;

   logic       clk_1kHz = 1'b0;
   logic       rst;
   logic [7:0] row;
   logic [7:0] col_r;
   logic [7:0] col_g;
   logic       err_clr;
   logic [2:0] rd_row_sel;

   logic [7:0] s_rd_r, s_rd_g, s_cnt;
   logic       s_pulse, s_valid, s_row_err, s_seq_err;
   logic [7:0] l_rd_r, l_rd_g, l_cnt;
   logic       l_pulse, l_valid, l_row_err, l_seq_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_1kHz = ~clk_1kHz;

   matrix_scan_decoder #(.STRICT_ORDER(1)) dut_s (
      .clk_1kHz(clk_1kHz), .rst(rst), .row(row), .col_r(col_r), .col_g(col_g),
      .err_clr(err_clr), .rd_row_sel(rd_row_sel), .rd_r(s_rd_r), .rd_g(s_rd_g),
      .frame_pulse(s_pulse), .frame_valid(s_valid), .frame_cnt(s_cnt),
      .row_err(s_row_err), .seq_err(s_seq_err));

   matrix_scan_decoder #(.STRICT_ORDER(0)) dut_l (
      .clk_1kHz(clk_1kHz), .rst(rst), .row(row), .col_r(col_r), .col_g(col_g),
      .err_clr(err_clr), .rd_row_sel(rd_row_sel), .rd_r(l_rd_r), .rd_g(l_rd_g),
      .frame_pulse(l_pulse), .frame_valid(l_valid), .frame_cnt(l_cnt),
      .row_err(l_row_err), .seq_err(l_seq_err));

   typedef struct packed {
      logic [7:0] row;
      logic [7:0] cr;
      logic [7:0] cg;
      logic       exp_pulse;
      logic       exp_valid;
      logic [7:0] exp_cnt;
   } scan_vec_t;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] exp_r;
      logic [7:0] exp_g;
   } rd_vec_t;

   scan_vec_t scan_tbl [10];
   rd_vec_t   rd_tbl   [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] rmask(input int k);
      logic [7:0] one;
      one = 8'd1;
      return ~(one << k);
   endfunction

   // Present one sample, then sample outputs 1 time unit after the edge.
   task automatic step(input logic [7:0] r, input logic [7:0] cr, input logic [7:0] cg);
      row   = r;
      col_r = cr;
      col_g = cg;
      @(posedge clk_1kHz);
      #1;
   endtask

   task automatic idle();
      step(8'hFF, 8'h00, 8'h00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_r"},    {24'd0, s_rd_r},    32'd0);
      chk({tag, "_rd_g"},    {24'd0, s_rd_g},    32'd0);
      chk({tag, "_pulse"},   {31'd0, s_pulse},   32'd0);
      chk({tag, "_valid"},   {31'd0, s_valid},   32'd0);
      chk({tag, "_cnt"},     {24'd0, s_cnt},     32'd0);
      chk({tag, "_row_err"}, {31'd0, s_row_err}, 32'd0);
      chk({tag, "_seq_err"}, {31'd0, s_seq_err}, 32'd0);
      chk({tag, "_l_valid"}, {31'd0, l_valid},   32'd0);
   endtask

   initial begin
      logic pulse_seen;
      logic [7:0] v;
      int ord [8];

      rst = 1'b1; row = 8'hFF; col_r = 8'h00; col_g = 8'h00;
      err_clr = 1'b0; rd_row_sel = 3'd0;

      // Fill the vector tables.
      for (int i = 0; i < 10; i++) begin
         v = 8'h11 * i[7:0];
         scan_tbl[i].row       = (i < 8) ? rmask(i) : 8'hFF;
         scan_tbl[i].cr        = (i < 8) ? v : 8'h00;
         scan_tbl[i].cg        = (i < 8) ? ~v : 8'h00;
         scan_tbl[i].exp_pulse = (i == 8);
         scan_tbl[i].exp_valid = (i >= 8);
         scan_tbl[i].exp_cnt   = (i >= 8) ? 8'd1 : 8'd0;
      end
      for (int k = 0; k < 8; k++) begin
         v = 8'h11 * k[7:0];
         rd_tbl[k].sel   = k[2:0];
         rd_tbl[k].exp_r = v;
         rd_tbl[k].exp_g = ~v;
      end

      // Reset state.
      do_reset();
      chk_all_zero("reset");

      // Partial frame with idles in between: nothing committed.
      pulse_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(rmask(k), 8'hEE, 8'hEE);
         pulse_seen |= s_pulse;
         idle();
         pulse_seen |= s_pulse;
      end
      for (int i = 0; i < 5; i++) begin
         idle();
         pulse_seen |= s_pulse;
      end
      chk("partial_no_pulse", {31'd0, pulse_seen}, 32'd0);
      chk("partial_valid", {31'd0, s_valid}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         rd_row_sel = k[2:0];
         idle();
         chk("partial_rd_r", {24'd0, s_rd_r}, 32'd0);
         chk("partial_rd_g", {24'd0, s_rd_g}, 32'd0);
      end
      rd_row_sel = 3'd0;
      do_reset();

      // Full in-order frame from the table.
      for (int i = 0; i < 10; i++) begin
         step(scan_tbl[i].row, scan_tbl[i].cr, scan_tbl[i].cg);
         chk("f1_pulse", {31'd0, s_pulse}, {31'd0, scan_tbl[i].exp_pulse});
         chk("f1_valid", {31'd0, s_valid}, {31'd0, scan_tbl[i].exp_valid});
         chk("f1_cnt",   {24'd0, s_cnt},   {24'd0, scan_tbl[i].exp_cnt});
         chk("f1_row_err", {31'd0, s_row_err}, 32'd0);
         chk("f1_seq_err", {31'd0, s_seq_err}, 32'd0);
      end

      // Read back every row of the committed frame.
      for (int i = 0; i < 8; i++) begin
         rd_row_sel = rd_tbl[i].sel;
         idle();
         chk("f1_rd_r", {24'd0, s_rd_r}, {24'd0, rd_tbl[i].exp_r});
         chk("f1_rd_g", {24'd0, s_rd_g}, {24'd0, rd_tbl[i].exp_g});
      end

      // Frame 2: multi-row sample of unseen rows 6,7 mid-frame.
      step(rmask(0), 8'hA0, 8'h00);
      step(rmask(1), 8'hA1, 8'h01);
      step(8'h3F, 8'hFF, 8'hFF);
      for (int k = 2; k < 7; k++) step(rmask(k), 8'hA0 | k[7:0], k[7:0]);
      idle();
      chk("f2_row_err", {31'd0, s_row_err}, 32'd1);
      chk("f2_no_early_pulse", {31'd0, s_pulse}, 32'd0);
      idle();
      chk("f2_no_early_pulse2", {31'd0, s_pulse}, 32'd0);
      step(rmask(7), 8'hA7, 8'h07);
      idle();
      chk("f2_pulse", {31'd0, s_pulse}, 32'd1);
      chk("f2_cnt", {24'd0, s_cnt}, 32'd2);
      chk("f2_seq_err", {31'd0, s_seq_err}, 32'd0);
      err_clr = 1'b1;
      idle();
      err_clr = 1'b0;
      chk("f2_row_err_clr", {31'd0, s_row_err}, 32'd0);

      // Frame 3: out-of-order rows; read row 3 on the commit edge.
      ord = '{0, 1, 3, 2, 4, 5, 6, 7};
      for (int i = 0; i < 8; i++)
         step(rmask(ord[i]), 8'h5A ^ ord[i][7:0], 8'h0F + ord[i][7:0]);
      rd_row_sel = 3'd3;
      idle();
      chk("f3_pulse", {31'd0, s_pulse}, 32'd1);
      chk("f3_cnt", {24'd0, s_cnt}, 32'd3);
      chk("f3_precommit_rd_r", {24'd0, s_rd_r}, 32'hA3);
      chk("f3_precommit_rd_g", {24'd0, s_rd_g}, 32'h03);
      chk("f3_seq_err_strict", {31'd0, s_seq_err}, 32'd1);
      chk("f3_seq_err_lax", {31'd0, l_seq_err}, 32'd0);
      idle();
      chk("f3_rd_r3", {24'd0, s_rd_r}, 32'h59);
      chk("f3_rd_g3", {24'd0, s_rd_g}, 32'h12);
      rd_row_sel = 3'd2;
      idle();
      chk("f3_rd_r2", {24'd0, s_rd_r}, 32'h58);
      chk("f3_rd_g2", {24'd0, s_rd_g}, 32'h11);
      chk("f3_lax_rd_r2", {24'd0, l_rd_r}, 32'h58);

      // Clear and new multi-row error on the same edge: set wins.
      step(8'h00, 8'h00, 8'h00);
      err_clr = 1'b1;
      idle();
      chk("setwins_row_err", {31'd0, s_row_err}, 32'd1);
      chk("setwins_seq_err_clr", {31'd0, s_seq_err}, 32'd0);
      idle();
      err_clr = 1'b0;
      chk("clr_row_err", {31'd0, s_row_err}, 32'd0);

      // Frame counter wrap: 253 more frames bring the count to 256 = 0.
      for (int f = 0; f < 253; f++)
         for (int k = 0; k < 8; k++) step(rmask(k), k[7:0], k[7:0]);
      idle();
      chk("wrap_pulse", {31'd0, s_pulse}, 32'd1);
      chk("wrap_cnt", {24'd0, s_cnt}, 32'd0);
      chk("wrap_valid", {31'd0, s_valid}, 32'd1);
      chk("wrap_seq_err", {31'd0, s_seq_err}, 32'd0);

      // Reset after rows 0..5 of a new frame, then a fresh wrapped-order scan.
      for (int k = 0; k < 6; k++) step(rmask(k), 8'h77, 8'h77);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      rd_row_sel = 3'd4;
      chk_all_zero("midrst");
      ord = '{3, 4, 5, 6, 7, 0, 1, 2};
      for (int i = 0; i < 8; i++) begin
         v = 8'hC0 | ord[i][7:0];
         step(rmask(ord[i]), v, ~v);
         chk("post_rst_no_pulse", {31'd0, s_pulse}, 32'd0);
      end
      idle();
      chk("post_rst_pulse", {31'd0, s_pulse}, 32'd1);
      chk("post_rst_cnt", {24'd0, s_cnt}, 32'd1);
      chk("post_rst_valid", {31'd0, s_valid}, 32'd1);
      chk("post_rst_seq_err", {31'd0, s_seq_err}, 32'd0);
      idle();
      chk("post_rst_rd_r4", {24'd0, s_rd_r}, 32'hC4);
      chk("post_rst_rd_g4", {24'd0, s_rd_g}, 32'h3B);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/matrix_scan_decoder.md
MATRIX_SCAN_DECODER -- requirements
Module: matrix_scan_decoder

Interface
REQ-001 SHALL have parameter STRICT_ORDER, default 1, meaning 1 enables row-sequence checking and 0 disables it.
REQ-002 SHALL have port clk_1kHz, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port row, input, 8, matrix row select, active-low, bit k = row k.
REQ-005 SHALL have port col_r, input, 8, red column data, active-high, bit j = column j.
REQ-006 SHALL have port col_g, input, 8, green column data, active-high, bit j = column j.
REQ-007 SHALL have port err_clr, input, 1, clears the sticky error flags.
REQ-008 SHALL have port rd_row_sel, input, 3, selects the captured-frame row to read back.
REQ-009 SHALL have port rd_r, output, 8, red data of the selected row in the captured frame.
REQ-010 SHALL have port rd_g, output, 8, green data of the selected row in the captured frame.
REQ-011 SHALL have port frame_pulse, output, 1, one-cycle strobe when a frame is committed.
REQ-012 SHALL have port frame_valid, output, 1, high once at least one frame has been committed since reset.
REQ-013 SHALL have port frame_cnt, output, 8, count of committed frames.
REQ-014 SHALL have port row_err, output, 1, sticky flag for more than one row active in a sample.
REQ-015 SHALL have port seq_err, output, 1, sticky flag for an out-of-order row.

Function
REQ-016 SHALL register row, col_r and col_g into an input stage on every clock edge; all decoding SHALL use the registered copy.
REQ-017 SHALL classify each registered sample as exactly one of three cases:
- IDLE: row == 8'hFF.
- ROW(k): exactly one bit k of row is low.
- MULTI: two or more bits of row are low.
REQ-018 On IDLE, the decoder SHALL leave the shadow buffer, the seen mask and the last-row register unchanged.
REQ-019 On ROW(k), the decoder SHALL write col_r/col_g into shadow row k, set seen[k] and set last_row to k, all on the edge following registration.
REQ-020 On a repeated ROW(k) with the same k, the decoder SHALL overwrite shadow row k with the newer data.
REQ-021 On MULTI, the decoder SHALL discard the sample and set row_err; seen, shadow and last_row SHALL NOT change.
REQ-022 When a ROW(k) write makes seen == 8'hFF, the decoder SHALL, on that same edge:
- copy all 8 shadow rows, including row k's new data, into the frame buffer;
- clear seen to 0;
- assert frame_pulse for exactly the following cycle;
- set frame_valid;
- increment frame_cnt modulo 256 (255 wraps to 0).
REQ-023 Latency SHALL be 2 clocks from the edge that presents the completing row's sample at the inputs to the frame_pulse high cycle.
REQ-024 With STRICT_ORDER = 1, a ROW(k) with k != last_row and k != (last_row + 1) mod 8 SHALL set seq_err; the data SHALL still be written per REQ-019.
REQ-025 The sequence check SHALL be skipped for the first ROW sample after reset.
REQ-026 With STRICT_ORDER = 0, seq_err SHALL remain 0.
REQ-027 err_clr SHALL clear row_err and seq_err on the next edge; if an error condition occurs on the same edge, the flag SHALL be set (set wins).
REQ-028 rd_r/rd_g SHALL be registered: the frame-buffer data for rd_row_sel sampled at edge N SHALL appear after edge N.
REQ-029 A read of the row being committed on the same edge SHALL return the pre-commit data.
REQ-030 The frame buffer SHALL change only on a commit; a partial frame SHALL never be visible on rd_r/rd_g.

Reset
REQ-031 rst SHALL take priority over all other inputs on the edge it is sampled.
REQ-032 On rst, the following SHALL clear to 0:
- input stage (row register set to 8'hFF);
- shadow buffer, frame buffer and seen;
- last_row and the first-sample flag;
- rd_r, rd_g, frame_pulse, frame_valid, frame_cnt, row_err, seq_err.
REQ-033 A reset mid-frame SHALL discard the partial frame; capture restarts from an empty seen mask.

Verification
REQ-034 Scan rows 0..7 in order, each with col_r = 8'h11*k and col_g = ~col_r -> frame_pulse high once, 2 cycles after row 7 is presented; frame_cnt = 1; every row k reads back its values; no errors.
REQ-035 Scan rows 0..3 only, interleaved with IDLE samples, then hold -> no frame_pulse, frame_valid = 0, rd_r/rd_g stay 0.
REQ-036 Apply row = 8'hFC mid-frame -> row_err = 1 and seen unchanged; completing the frame still commits it; err_clr then clears row_err.
REQ-037 With STRICT_ORDER = 1, scan 0,1,3,2,4,5,6,7 -> seq_err = 1 and the frame commits with correct data; repeat with STRICT_ORDER = 0 -> seq_err = 0.
REQ-038 Scan 256 complete frames -> frame_cnt wraps to 0 and frame_valid stays 1.
REQ-039 Assert rst after rows 0..5 of frame 2 -> all outputs 0; a fresh 0..7 scan then commits with frame_cnt = 1.
